// File: rtl/sdram_map_pkg.sv
// ---------------------------------------------------------------------------
// Module   : sdram_map_pkg
// Brief    : Shared types and the host-address split for the SDRAM mapper.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sdram_map_pkg;

  localparam logic [1:0] COLBITS_8  = 2'b00;
  localparam logic [1:0] COLBITS_9  = 2'b01;
  localparam logic [1:0] COLBITS_10 = 2'b10;
  localparam logic [1:0] COLBITS_11 = 2'b11;

  localparam int ROW_W     = 12;
  localparam int BANK_W    = 2;
  localparam int COL_W     = 12;
  localparam int NUM_BANKS = 1 << BANK_W;
  localparam int SPLIT_AW  = 64;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    logic [COL_W-1:0]  col;
    logic              wr;
  } map_req_t;

  // Column width is 8 + colbits; bank sits just above it, row above the bank.
  function automatic map_req_t split_addr(input logic [SPLIT_AW-1:0] addr,
                                          input logic [1:0]          colbits);
    map_req_t          r;
    int unsigned       cb;
    logic [SPLIT_AW-1:0] mask;
    cb     = 32'd8 + 32'(colbits);
    mask   = (64'd1 << cb) - 64'd1;
    r.col  = COL_W'(addr & mask);
    r.bank = BANK_W'(addr >> cb);
    r.row  = ROW_W'(addr >> (cb + 32'd2));
    r.wr   = 1'b0;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_map_fifo.sv
// ---------------------------------------------------------------------------
// Module   : sdram_map_fifo
// Brief    : Power-of-two FIFO holding mapped requests; head shown as zero when empty.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdram_map_fifo
  import sdram_map_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  map_req_t               push_data_i,
  input  logic                   pop_i,
  output map_req_t               head_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  map_req_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
  assign valid_o = (level_q != '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible while level is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = valid_o ? mem_q[rptr_q] : '0;
  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/sdram_addr_mapper.sv
// ---------------------------------------------------------------------------
// Module   : sdram_addr_mapper
// Brief    : Splits host addresses into row/bank/column, buffers them and tracks open rows.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdram_addr_mapper
  import sdram_map_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int APP_AW     = 26
) (
  input  logic                          sdram_clk,
  input  logic                          sdram_resetn,
  input  logic [1:0]                    cfg_colbits,
  input  logic                          precharge_all,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [APP_AW-1:0]             req_addr,
  input  logic                          req_wr,
  output logic                          map_valid,
  input  logic                          map_ready,
  output logic [ROW_W-1:0]              map_row,
  output logic [BANK_W-1:0]             map_bank,
  output logic [COL_W-1:0]              map_col,
  output logic                          map_wr,
  output logic                          map_page_hit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  map_req_t                          req_split;
  map_req_t                          head;
  logic                              fifo_full;
  logic                              push, pop;
  logic [NUM_BANKS-1:0]              open_q, open_d;
  logic [NUM_BANKS-1:0][ROW_W-1:0]   row_q, row_d;

  always_comb begin
    req_split    = split_addr(SPLIT_AW'(req_addr), cfg_colbits);
    req_split.wr = req_wr;
  end

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = map_valid && map_ready;

  sdram_map_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (sdram_clk),
    .rst_ni      (sdram_resetn),
    .push_i      (push),
    .push_data_i (req_split),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (map_valid),
    .full_o      (fifo_full),
    .level_o     (fifo_level)
  );

  assign map_row  = head.row;
  assign map_bank = head.bank;
  assign map_col  = head.col;
  assign map_wr   = head.wr;

  assign map_page_hit = open_q[map_bank] && (row_q[map_bank] == map_row);

  // Handshake update is applied after precharge so it wins for its own bank.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    if (precharge_all) open_d = '0;
    if (pop) begin
      open_d[map_bank] = 1'b1;
      row_d[map_bank]  = map_row;
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      open_q <= '0;
      row_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_addr_mapper.sv
// ---------------------------------------------------------------------------
// Module   : tb_sdram_addr_mapper
// Brief    : Directed scoreboard bench for sdram_addr_mapper.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sdram_addr_mapper;
  import sdram_map_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        sdram_resetn;
  logic [1:0]  cfg_colbits;
  logic        precharge_all;
  logic        req_valid;
  logic        req_ready;
  logic [25:0] req_addr;
  logic        req_wr;
  logic        map_valid;
  logic        map_ready;
  logic [11:0] map_row;
  logic [1:0]  map_bank;
  logic [11:0] map_col;
  logic        map_wr;
  logic        map_page_hit;
  logic [1:0]  fifo_level;

  int checks   = 0;
  int failures = 0;

  map_req_t    q[$];
  logic [3:0]  open_m;
  logic [11:0] row_m [4];

  always #5 clk = ~clk;

  sdram_addr_mapper #(.FIFO_DEPTH(DEPTH), .APP_AW(26)) dut (
    .sdram_clk     (clk),
    .sdram_resetn  (sdram_resetn),
    .cfg_colbits   (cfg_colbits),
    .precharge_all (precharge_all),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wr        (req_wr),
    .map_valid     (map_valid),
    .map_ready     (map_ready),
    .map_row       (map_row),
    .map_bank      (map_bank),
    .map_col       (map_col),
    .map_wr        (map_wr),
    .map_page_hit  (map_page_hit),
    .fifo_level    (fifo_level)
  );

  function automatic map_req_t model_split(input logic [25:0] a, input logic [1:0] cb,
                                           input logic wr);
    map_req_t r;
    r.wr = wr;
    case (cb)
      2'b00:   begin r.col = {4'h0, a[7:0]};  r.bank = a[9:8];   r.row = a[21:10]; end
      2'b01:   begin r.col = {3'h0, a[8:0]};  r.bank = a[10:9];  r.row = a[22:11]; end
      2'b10:   begin r.col = {2'h0, a[9:0]};  r.bank = a[11:10]; r.row = a[23:12]; end
      default: begin r.col = {1'h0, a[10:0]}; r.bank = a[12:11]; r.row = a[24:13]; end
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Compare outputs against the scoreboard, clock once, then update the model.
  task automatic tick(output bit acc);
    map_req_t head;
    bit       hs_req, hs_map, rst_now, pre_now;
    logic [25:0] a_now;
    logic [1:0]  cb_now;
    logic        wr_now;
    chk("req_ready", {31'd0, req_ready}, {31'd0, q.size() != DEPTH});
    chk("map_valid", {31'd0, map_valid}, {31'd0, q.size() != 0});
    chk("fifo_level", {30'd0, fifo_level}, q.size());
    head = '0;
    if (q.size() != 0) begin
      head = q[0];
      chk("map_row", {20'd0, map_row}, {20'd0, head.row});
      chk("map_bank", {30'd0, map_bank}, {30'd0, head.bank});
      chk("map_col", {20'd0, map_col}, {20'd0, head.col});
      chk("map_wr", {31'd0, map_wr}, {31'd0, head.wr});
      chk("page_hit", {31'd0, map_page_hit},
          {31'd0, open_m[head.bank] && (row_m[head.bank] == head.row)});
    end
    rst_now = !sdram_resetn;
    pre_now = precharge_all;
    hs_req  = req_valid && (q.size() != DEPTH);
    hs_map  = map_ready && (q.size() != 0);
    a_now   = req_addr;
    cb_now  = cfg_colbits;
    wr_now  = req_wr;
    @(posedge clk);
    #1;
    acc = 1'b0;
    if (rst_now) begin
      q.delete();
      open_m = '0;
    end else begin
      if (pre_now) open_m = '0;
      if (hs_map) begin
        open_m[head.bank] = 1'b1;
        row_m[head.bank]  = head.row;
        void'(q.pop_front());
      end
      if (hs_req) begin
        q.push_back(model_split(a_now, cb_now, wr_now));
        acc = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [25:0] a, input logic wr);
    bit acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_wr    = wr;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL send_timeout observed=%0d expected=1", acc);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    map_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick(acc);
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL drain_timeout observed=%0d expected=0", q.size());
    end
  endtask

  initial begin
    bit acc;
    sdram_resetn  = 1'b0;
    cfg_colbits   = 2'b00;
    precharge_all = 1'b0;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_wr        = 1'b0;
    map_ready     = 1'b0;
    open_m        = '0;
    for (int i = 0; i < 4; i++) row_m[i] = '0;

    // Reset values
    @(posedge clk);
    #1;
    tick(acc);
    chk("rst_map_row", {20'd0, map_row}, 32'd0);
    chk("rst_map_bank", {30'd0, map_bank}, 32'd0);
    chk("rst_map_col", {20'd0, map_col}, 32'd0);
    chk("rst_map_wr", {31'd0, map_wr}, 32'd0);
    chk("rst_page_hit", {31'd0, map_page_hit}, 32'd0);
    sdram_resetn = 1'b1;
    tick(acc);

    // colbits=00 split
    map_ready = 1'b1;
    send(26'h0001A80, 1'b0);
    chk("s1_row", {20'd0, map_row}, 32'h006);
    chk("s1_bank", {30'd0, map_bank}, 32'd2);
    chk("s1_col", {20'd0, map_col}, 32'h080);
    chk("s1_hit", {31'd0, map_page_hit}, 32'd0);
    drain();

    // colbits=11 split, all ones
    cfg_colbits = 2'b11;
    send(26'h1FFFFFF, 1'b1);
    chk("s2_row", {20'd0, map_row}, 32'hFFF);
    chk("s2_bank", {30'd0, map_bank}, 32'd3);
    chk("s2_col", {20'd0, map_col}, 32'h7FF);
    chk("s2_wr", {31'd0, map_wr}, 32'd1);
    drain();

    // Page hit on bank 1 row 5, then precharge closes it
    cfg_colbits = 2'b00;
    send(26'h0001510, 1'b0);
    chk("s3_first_hit", {31'd0, map_page_hit}, 32'd0);
    send(26'h0001510, 1'b1);
    chk("s3_second_hit", {31'd0, map_page_hit}, 32'd1);
    drain();
    precharge_all = 1'b1;
    tick(acc);
    precharge_all = 1'b0;
    send(26'h0001510, 1'b0);
    chk("s3_after_pre_hit", {31'd0, map_page_hit}, 32'd0);
    drain();

    // Backpressure: fill, hold a third request, then release
    map_ready = 1'b0;
    send(26'h0000100, 1'b0);
    send(26'h0000200, 1'b1);
    req_valid = 1'b1;
    req_addr  = 26'h0000300;
    req_wr    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      chk("s4_no_accept", {31'd0, acc}, 32'd0);
    end
    chk("s4_ready_low", {31'd0, req_ready}, 32'd0);
    chk("s4_level_full", {30'd0, fifo_level}, 32'd2);
    chk("s4_head_col", {20'd0, map_col}, 32'h000);
    map_ready = 1'b1;
    send(26'h0000300, 1'b0);
    drain();

    // colbits change with buffered entries
    map_ready = 1'b0;
    send(26'h0000D23, 1'b0);
    send(26'h0003456, 1'b1);
    cfg_colbits = 2'b10;
    tick(acc);
    tick(acc);
    drain();
    send(26'h0ABCDEF, 1'b0);
    chk("s5_row", {20'd0, map_row}, 32'hABC);
    chk("s5_bank", {30'd0, map_bank}, 32'd3);
    chk("s5_col", {20'd0, map_col}, 32'h1EF);
    drain();

    // Reset with full FIFO
    cfg_colbits = 2'b00;
    map_ready   = 1'b0;
    send(26'h0001510, 1'b0);
    send(26'h0002000, 1'b1);
    sdram_resetn = 1'b0;
    tick(acc);
    sdram_resetn = 1'b1;
    chk("s6_valid", {31'd0, map_valid}, 32'd0);
    chk("s6_level", {30'd0, fifo_level}, 32'd0);
    chk("s6_ready", {31'd0, req_ready}, 32'd1);
    map_ready = 1'b1;
    tick(acc);
    send(26'h0001510, 1'b0);
    chk("s6_bank_closed", {31'd0, map_page_hit}, 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
